// File: rtl/tcu_fedp_sequencer.sv
// tcu_fedp_sequencer: issue-side controller chaining FEDP k-chunk results.
// Optional TCU_FEDP_SEQ_PERF_EN adds busy / operand-stall perf counters.
module tcu_fedp_sequencer #(
  parameter int N         = 2,
  parameter int LATENCY   = 4,
  parameter int MAX_STEPS = 8,
  parameter int ID_W      = 8,
  parameter int MASK_W    = 8,
  localparam int STEPS_W  = $clog2(MAX_STEPS + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_fmt_s,
  input  logic [3:0]          req_fmt_d,
  input  logic [STEPS_W-1:0]  req_steps,
  input  logic [31:0]         req_c_init,
  input  logic [ID_W-1:0]     req_id,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [N*32-1:0]     op_a_row,
  input  logic [N*32-1:0]     op_b_col,
  input  logic [MASK_W-1:0]   op_vld_mask,
  output logic                fedp_enable,
  output logic [MASK_W-1:0]   fedp_vld_mask,
  output logic [3:0]          fedp_fmt_s,
  output logic [3:0]          fedp_fmt_d,
  output logic [N*32-1:0]     fedp_a_row,
  output logic [N*32-1:0]     fedp_b_col,
  output logic [31:0]         fedp_c_val,
  input  logic [31:0]         fedp_d_val,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_d_val,
  output logic [ID_W-1:0]     rsp_id
`ifdef TCU_FEDP_SEQ_PERF_EN
  ,
  output logic [31:0]         perf_busy_cycles,
  output logic [31:0]         perf_op_stall_cycles
`endif
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RSP   = 2'd3;

  localparam logic [STEPS_W-1:0] MAX_S =
    STEPS_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] LAT_C =
    CNT_W'(LATENCY);

  if (LATENCY < 1) begin : g_lat_check
    $error("LATENCY must be >= 1");
  end

  logic [1:0]         state;
  logic [3:0]         fmt_s_r;
  logic [3:0]         fmt_d_r;
  logic [ID_W-1:0]    id_r;
  logic [STEPS_W-1:0] steps_left;
  logic [31:0]        acc_r;
  logic [CNT_W-1:0]   wait_cnt;

  logic is_idle;
  logic is_issue;
  logic is_wait;
  logic is_rsp;
  logic issue;
  logic last_wait;
  logic last_step;

  // State decode and per-cycle qualifiers.
  always_comb begin
    is_idle   = (state == S_IDLE);
    is_issue  = (state == S_ISSUE);
    is_wait   = (state == S_WAIT);
    is_rsp    = (state == S_RSP);
    issue     = is_issue & op_valid;
    last_wait = is_wait & (wait_cnt == CNT_W'(1));
    last_step = (steps_left == STEPS_W'(1));
  end

  // Control FSM: accept, issue one chunk, wait out the pipe, respond.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      unique case (1'b1)
        is_idle: begin
          if (req_valid) begin
            if (req_steps == '0) state <= S_RSP;
            else                 state <= S_ISSUE;
          end
        end
        is_issue: begin
          if (op_valid) state <= S_WAIT;
        end
        is_wait: begin
          if (last_wait) begin
            if (last_step) state <= S_RSP;
            else           state <= S_ISSUE;
          end
        end
        is_rsp: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Job context latched at acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fmt_s_r <= '0;
      fmt_d_r <= '0;
      id_r    <= '0;
    end else if (is_idle && req_valid) begin
      fmt_s_r <= req_fmt_s;
      fmt_d_r <= req_fmt_d;
      id_r    <= req_id;
    end
  end

  // Accumulator chain and remaining-step count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r      <= '0;
      steps_left <= '0;
    end else if (is_idle && req_valid) begin
      acc_r      <= req_c_init;
      steps_left <= req_steps;
    end else if (last_wait) begin
      acc_r      <= fedp_d_val;
      steps_left <= steps_left - 1'b1;
    end
  end

  // Pipe-depth countdown; cleared on reset so no stale capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (issue) begin
      wait_cnt <= LAT_C;
    end else if (is_wait) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // Output drive: handshakes, FEDP operands, response.
  always_comb begin
    req_ready     = is_idle;
    op_ready      = is_issue;
    fedp_enable   = is_issue | is_wait;
    fedp_vld_mask = issue ? op_vld_mask : '0;
    fedp_a_row    = is_issue ? op_a_row : '0;
    fedp_b_col    = is_issue ? op_b_col : '0;
    fedp_c_val    = acc_r;
    fedp_fmt_s    = fmt_s_r;
    fedp_fmt_d    = fmt_d_r;
    rsp_valid     = is_rsp;
    rsp_d_val     = is_rsp ? acc_r : '0;
    rsp_id        = is_rsp ? id_r : '0;
  end

`ifdef TCU_FEDP_SEQ_PERF_EN
  // Saturating busy and operand-starvation counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_busy_cycles     <= '0;
      perf_op_stall_cycles <= '0;
    end else begin
      if (!is_idle && perf_busy_cycles != '1)
        perf_busy_cycles <= perf_busy_cycles + 1'b1;
      if (is_issue && !op_valid &&
          perf_op_stall_cycles != '1)
        perf_op_stall_cycles <=
          perf_op_stall_cycles + 1'b1;
    end
  end
`endif

  steps_legal: assert property (
    @(posedge clk) disable iff (!reset_n)
    (is_idle && req_valid) |-> (req_steps <= MAX_S)
  ) else $error("req_steps exceeds MAX_STEPS");

endmodule

// File: tb/tb_tcu_fedp_sequencer.sv
// tb_tcu_fedp_sequencer: scoreboard bench with an fp32 FEDP model.
// Directed test-plan jobs followed by randomized jobs.
module tb_tcu_fedp_sequencer;
  localparam int N = 2;
  localparam int LAT = 4;
  localparam int MAXS = 8;
  localparam int ID_W = 8;
  localparam int MASK_W = 8;
  localparam int SW = $clog2(MAXS + 1);

  logic clk;
  logic reset_n;
  logic req_valid, req_ready;
  logic [3:0] req_fmt_s, req_fmt_d;
  logic [SW-1:0] req_steps;
  logic [31:0] req_c_init;
  logic [ID_W-1:0] req_id;
  logic op_valid, op_ready;
  logic [N*32-1:0] op_a_row, op_b_col;
  logic [MASK_W-1:0] op_vld_mask;
  logic fedp_enable;
  logic [MASK_W-1:0] fedp_vld_mask;
  logic [3:0] fedp_fmt_s, fedp_fmt_d;
  logic [N*32-1:0] fedp_a_row, fedp_b_col;
  logic [31:0] fedp_c_val, fedp_d_val;
  logic rsp_valid, rsp_ready;
  logic [31:0] rsp_d_val;
  logic [ID_W-1:0] rsp_id;
`ifdef TCU_FEDP_SEQ_PERF_EN
  logic [31:0] perf_busy_cycles, perf_op_stall_cycles;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] exp_c_q[$];
  logic [39:0] exp_rsp_q[$];
  logic [3:0] cur_fmt_s, cur_fmt_d;
  logic [31:0] last_rsp_d;
  logic [7:0] mon_mask;
  logic [63:0] ca[MAXS];
  logic [63:0] cb[MAXS];
  logic [7:0] cm[MAXS];
  logic [31:0] pipe[LAT];

  tcu_fedp_sequencer #(
    .N(N), .LATENCY(LAT), .MAX_STEPS(MAXS),
    .ID_W(ID_W), .MASK_W(MASK_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt_s(req_fmt_s), .req_fmt_d(req_fmt_d),
    .req_steps(req_steps), .req_c_init(req_c_init),
    .req_id(req_id),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a_row(op_a_row), .op_b_col(op_b_col),
    .op_vld_mask(op_vld_mask),
    .fedp_enable(fedp_enable),
    .fedp_vld_mask(fedp_vld_mask),
    .fedp_fmt_s(fedp_fmt_s), .fedp_fmt_d(fedp_fmt_d),
    .fedp_a_row(fedp_a_row), .fedp_b_col(fedp_b_col),
    .fedp_c_val(fedp_c_val), .fedp_d_val(fedp_d_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_d_val(rsp_d_val), .rsp_id(rsp_id)
`ifdef TCU_FEDP_SEQ_PERF_EN
    ,
    .perf_busy_cycles(perf_busy_cycles),
    .perf_op_stall_cycles(perf_op_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic real fp2r(input logic [31:0] x);
    real m;
    int e;
    if (x[30:23] == 8'h00) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    real v;
    int e;
    logic s;
    logic [22:0] man;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    v = s ? -r : r;
    e = 127;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0) begin v = v * 2.0; e--; end
    man = 23'($rtoi((v - 1.0) * 8388608.0));
    return {s, 8'(e), man};
  endfunction

  // d = c + sum of enabled lane products (exact for bench values)
  function automatic logic [31:0] fedp_fn(
    input logic [31:0] c, input logic [63:0] a,
    input logic [63:0] b, input logic [7:0] m);
    real r;
    r = fp2r(c);
    for (int i = 0; i < N; i++)
      if (m[i]) r = r + fp2r(a[i*32 +: 32]) * fp2r(b[i*32 +: 32]);
    return r2fp(r);
  endfunction

  function automatic logic [31:0] rnd_fp();
    int k;
    k = int'($urandom_range(16)) - 8;
    return r2fp(real'(k) * 0.5);
  endfunction

  // FEDP model: LAT-deep pipe that advances only when enabled
  always @(posedge clk) begin
    if (fedp_enable) begin
      pipe[0] <= fedp_fn(fedp_c_val, fedp_a_row,
                         fedp_b_col, fedp_vld_mask);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign fedp_d_val = pipe[LAT-1];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: issue-cycle and response-handshake scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      mon_mask = (op_valid && op_ready) ? op_vld_mask : 8'h00;
      check("fedp_vld_mask", 64'(fedp_vld_mask), 64'(mon_mask));
      if (op_valid && op_ready) begin
        check("issue_enable", 64'(fedp_enable), 64'd1);
        check("issue_fmt", 64'({fedp_fmt_s, fedp_fmt_d}),
              64'({cur_fmt_s, cur_fmt_d}));
        check("issue_a_row", fedp_a_row, op_a_row);
        check("issue_b_col", fedp_b_col, op_b_col);
        if (exp_c_q.size() == 0)
          check("issue_unexpected", 64'(exp_c_q.size()), 64'd1);
        else
          check("issue_c_val", 64'(fedp_c_val),
                64'(exp_c_q.pop_front()));
      end
      if (rsp_valid && rsp_ready) begin
        last_rsp_d = rsp_d_val;
        if (exp_rsp_q.size() == 0)
          check("rsp_unexpected", 64'(exp_rsp_q.size()), 64'd1);
        else
          check("rsp_data_id", 64'({rsp_id, rsp_d_val}),
                64'(exp_rsp_q.pop_front()));
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_ctl", 64'({req_ready, op_ready, fedp_enable,
          rsp_valid}), 64'(4'b1000));
    check("rst_mask_fmt", 64'({fedp_vld_mask, fedp_fmt_s,
          fedp_fmt_d}), 64'd0);
    check("rst_c_val", 64'(fedp_c_val), 64'd0);
    check("rst_a_row", fedp_a_row, 64'd0);
    check("rst_b_col", fedp_b_col, 64'd0);
    check("rst_rsp", 64'({rsp_d_val, rsp_id}), 64'd0);
`ifdef TCU_FEDP_SEQ_PERF_EN
    check("rst_perf", {perf_busy_cycles, perf_op_stall_cycles},
          64'd0);
`endif
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) begin
      ca[k] = {rnd_fp(), rnd_fp()};
      cb[k] = {rnd_fp(), rnd_fp()};
      cm[k] = 8'($urandom_range(255));
    end
  endtask

  // One job: hold = cycles rsp_ready stays low once valid (>=1),
  // abort_at = chunk index after whose issue reset is pulsed (-1 none)
  task automatic do_job(input int steps, input logic [31:0] c_init,
                        input logic [7:0] id, input int stall,
                        input int hold, input int abort_at);
    logic [31:0] acc;
    int n_iss, t_acc, t_rsp, lat, n;
`ifdef TCU_FEDP_SEQ_PERF_EN
    logic [31:0] pb0, ps0;
`endif
    @(posedge clk); #1;
    cur_fmt_s = 4'($urandom_range(15));
    cur_fmt_d = 4'($urandom_range(15));
    req_fmt_s = cur_fmt_s;
    req_fmt_d = cur_fmt_d;
    req_steps = SW'(steps);
    req_c_init = c_init;
    req_id = id;
    req_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    check("req_accept", 64'(req_ready), 64'd1);
    if (!req_ready) begin req_valid = 1'b0; return; end
    t_acc = cyc;
    check("idle_enable", 64'(fedp_enable), 64'd0);
`ifdef TCU_FEDP_SEQ_PERF_EN
    pb0 = perf_busy_cycles;
    ps0 = perf_op_stall_cycles;
`endif
    n_iss = (abort_at >= 0) ? abort_at + 1 : steps;
    acc = c_init;
    for (int k = 0; k < n_iss; k++) begin
      exp_c_q.push_back(acc);
      acc = fedp_fn(acc, ca[k], cb[k], cm[k]);
    end
    if (abort_at < 0) exp_rsp_q.push_back({id, acc});
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < n_iss; k++) begin
      if (k == 0) begin
        repeat (stall) begin
          @(negedge clk);
          check("op_ready_stall", 64'(op_ready), 64'd1);
          @(posedge clk); #1;
        end
      end
      op_valid = 1'b1;
      op_a_row = ca[k];
      op_b_col = cb[k];
      op_vld_mask = cm[k];
      n = 0;
      do begin @(negedge clk); n++; end while (!op_ready && n < 50);
      check("op_accept", 64'(op_ready), 64'd1);
      @(posedge clk); #1;
      op_valid = 1'b0;
      op_a_row = '0;
      op_b_col = '0;
      op_vld_mask = '0;
      if (n >= 50) return;
      if (k == abort_at) begin
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", 64'(req_ready), 64'd1);
        return;
      end
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 200);
    check("rsp_seen", 64'(rsp_valid), 64'd1);
    if (!rsp_valid) return;
    t_rsp = cyc;
    lat = steps * (LAT + 1) + 1 + ((steps > 0) ? stall : 0);
    check("rsp_latency", 64'(t_rsp - t_acc), 64'(lat));
`ifdef TCU_FEDP_SEQ_PERF_EN
    check("perf_busy", 64'(perf_busy_cycles - pb0), 64'(lat - 1));
    check("perf_stall", 64'(perf_op_stall_cycles - ps0),
          64'((steps > 0) ? stall : 0));
`endif
    for (int h = 0; h < hold; h++) begin
      if (h > 0) begin @(posedge clk); #1; @(negedge clk); end
      check("rsp_hold", 64'({rsp_valid, rsp_id, rsp_d_val}),
            64'({1'b1, id, acc}));
      check("rsp_hold_rdy", 64'(req_ready), 64'd0);
      check("rsp_enable", 64'(fedp_enable), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("hs_req_ready", 64'({rsp_valid, req_ready}), 64'(2'b10));
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("post_hs", 64'({rsp_valid, req_ready}), 64'(2'b01));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0;
    req_fmt_s = '0;
    req_fmt_d = '0;
    req_steps = '0;
    req_c_init = '0;
    req_id = '0;
    op_valid = 1'b0;
    op_a_row = '0;
    op_b_col = '0;
    op_vld_mask = '0;
    rsp_ready = 1'b0;
    cur_fmt_s = '0;
    cur_fmt_d = '0;
    last_rsp_d = '0;
    #3;
    check_reset_outputs();
    #10;
    reset_n = 1'b1;

    // 1.0*3.0 + 2.0*4.0 + 0.5 = 11.5
    ca[0] = {32'h40000000, 32'h3F800000};
    cb[0] = {32'h40800000, 32'h40400000};
    cm[0] = 8'h03;
    do_job(1, 32'h3F000000, 8'h12, 0, 1, -1);
    check("t1_d", 64'(last_rsp_d), 64'h41380000);

    for (int k = 0; k < 3; k++) begin
      ca[k] = {2{32'h3F800000}};
      cb[k] = {2{32'h3F800000}};
      cm[k] = 8'hFF;
    end
    do_job(3, 32'h0, 8'h34, 0, 1, -1);
    check("t2_d", 64'(last_rsp_d), 64'h40C00000);

    do_job(0, 32'h3F800000, 8'h56, 0, 1, -1);
    check("t3_d", 64'(last_rsp_d), 64'h3F800000);

    fill_random(1);
    do_job(1, rnd_fp(), 8'h78, 5, 1, -1);

    fill_random(2);
    do_job(2, rnd_fp(), 8'h9A, 0, 3, -1);

    fill_random(3);
    do_job(3, rnd_fp(), 8'hBC, 0, 1, 1);
    ca[0] = {32'h40000000, 32'h3F800000};
    cb[0] = {32'h40800000, 32'h40400000};
    cm[0] = 8'h03;
    do_job(1, 32'h3F000000, 8'hDE, 0, 1, -1);
    check("t6_d", 64'(last_rsp_d), 64'h41380000);

    for (int j = 0; j < 30; j++) begin
      int s;
      s = int'($urandom_range(MAXS));
      fill_random(MAXS);
      do_job(s, rnd_fp(), 8'($urandom_range(255)),
             int'($urandom_range(2)),
             int'($urandom_range(3, 1)), -1);
    end

    check("c_q_empty", 64'(exp_c_q.size()), 64'd0);
    check("rsp_q_empty", 64'(exp_rsp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tcu_fedp_sequencer.md
Name: tcu_fedp_sequencer

Overview:
Issue-side controller for the tensor-core fused dot-product unit. It accepts a dot-product job of STEPS k-chunks and streams each chunk's a_row/b_col operands into the FEDP. It feeds each FEDP result back as the next chunk's c_val, which serialises the accumulation chain. When the chain completes, it returns the final d_val on a valid/ready response port.

Parameters:
N, 2, FEDP elements per row/column (matches the FEDP's N)
LATENCY, 4, FEDP pipeline depth in enabled cycles; must be >=1 (static assert)
MAX_STEPS, 8, maximum k-chunks per job; STEPS_W = $clog2(MAX_STEPS+1)
ID_W, 8, job tag width
MASK_W, 8, vld_mask width (TCU_MAX_INPUTS)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  job request valid
req_ready  out  1  job request ready
req_fmt_s  in  4  source format
req_fmt_d  in  4  destination format
req_steps  in  STEPS_W  number of k-chunks (0..MAX_STEPS)
req_c_init  in  32  initial accumulator
req_id  in  ID_W  job tag
op_valid  in  1  operand chunk valid
op_ready  out  1  operand chunk ready
op_a_row  in  N*32  A chunk
op_b_col  in  N*32  B chunk
op_vld_mask  in  MASK_W  per-lane valid for this chunk
fedp_enable  out  1  FEDP pipeline advance
fedp_vld_mask  out  MASK_W  to FEDP vld_mask
fedp_fmt_s  out  4  to FEDP fmt_s
fedp_fmt_d  out  4  to FEDP fmt_d
fedp_a_row  out  N*32  to FEDP a_row
fedp_b_col  out  N*32  to FEDP b_col
fedp_c_val  out  32  to FEDP c_val
fedp_d_val  in  32  from FEDP d_val
rsp_valid  out  1  result valid
rsp_ready  in  1  result ready
rsp_d_val  out  32  final accumulated result
rsp_id  out  ID_W  job tag

Behaviour:
- State machine: IDLE, ISSUE, WAIT, RSP. Reset (async, reset_n low) forces IDLE immediately.
- Reset values: all registers are 0. Because the state is IDLE, req_ready=1. All other outputs are 0.
- IDLE: req_ready=1. On req_valid, latch fmt_s, fmt_d, id and steps_left=req_steps, and set acc_r=req_c_init. If req_steps==0, go to RSP; otherwise go to ISSUE.
- ISSUE: op_ready=1 and fedp_enable=1. On op_valid (the issue cycle T):
  - fedp_a_row, fedp_b_col and fedp_vld_mask pass through combinationally from op_*;
  - fedp_c_val=acc_r;
  - load wait_cnt=LATENCY and go to WAIT.
  While op_valid=0, fedp_vld_mask=0 and the state holds.
- fedp_vld_mask is 0 in every cycle that is not an issue cycle. fedp_a_row/b_col are 0 outside ISSUE. fedp_c_val=acc_r and fedp_fmt_* are the latched values in all states.
- WAIT: fedp_enable=1, op_ready=0. wait_cnt decrements each cycle. In the cycle with wait_cnt==1 (cycle T+LATENCY):
  - capture acc_r=fedp_d_val and decrement steps_left;
  - go to RSP if steps_left becomes 0, else go to ISSUE.
- Minimum step period is LATENCY+1 cycles. A job with S steps and no operand stalls reaches RSP S*(LATENCY+1)+1 cycles after acceptance.
- RSP: rsp_valid=1, rsp_d_val=acc_r, rsp_id=latched id, fedp_enable=0. Hold all three stable until rsp_ready; then go to IDLE. No new request is accepted in the same cycle as the response handshake.
- fedp_enable=0 in IDLE and RSP, so the FEDP pipeline is frozen while nothing is in flight.
- Integer formats use the same chaining: the 32-bit raw result is fed back as c_val.
- req_steps>MAX_STEPS is illegal. Behaviour is undefined; an assertion fires in simulation.
- Reset asserted mid-job: the job is dropped, no response is produced, and req_ready=1 after reset release. Any result still in the FEDP pipeline is ignored; it is never captured because wait_cnt is cleared.

Optional Feature:
TCU_FEDP_SEQ_PERF_EN: adds output ports perf_busy_cycles[31:0] and perf_op_stall_cycles[31:0].
- perf_busy_cycles increments every cycle the state is not IDLE.
- perf_op_stall_cycles increments every ISSUE cycle with op_valid=0.
- Both counters saturate at 0xFFFFFFFF and reset to 0.
Without the macro, the ports and counters do not exist.

Test Plan:
- fp32, N=2, LATENCY=4 (bench FEDP model), steps=1, a=[1.0,2.0], b=[3.0,4.0], c_init=0.5, id=0x12; operand presented at cycle 1 -> fedp_vld_mask nonzero only in cycle 1; rsp_valid at cycle 6 with d=0x41380000 (11.5) and id=0x12.
- steps=3, every chunk a=[1.0,1.0], b=[1.0,1.0], c_init=0 -> fedp_c_val=0, 2.0, 4.0 on successive issues; rsp d=0x40C00000 (6.0) at cycle 16.
- steps=0, c_init=0x3F800000 -> no FEDP issue, fedp_enable stays 0; rsp_valid at cycle 1 with d=0x3F800000.
- op_valid withheld 5 cycles in ISSUE -> op_ready held high, fedp_vld_mask=0 throughout, and the response is delayed by exactly 5 cycles; with perf enabled, perf_op_stall_cycles=5.
- rsp_ready low 3 cycles -> rsp_valid, rsp_d_val and rsp_id stable; req_ready=0 until the cycle after the handshake.
- reset_n pulsed low in WAIT of step 2 of 3 -> all outputs return to reset values asynchronously; after release a new steps=1 job completes correctly with no stale capture.
